// File: rtl/arbitro_turno.sv
// Turn controller for a two-player chess clock: whose turn it is, per-player
// countdown timers, move-register grant/strobe and time-expiry flags.
module arbitro_turno #(
    parameter int W             = 12,
    parameter int TEMPO_INICIAL = 600,
    parameter int INCREMENTO    = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         iniciar,
    input  logic         tick,
    input  logic         req_branca,
    input  logic         req_preta,
    input  logic         pausar,
    input  logic         jogada_valida,
    input  logic         jogada_invalida,
    output logic         gnt_branca,
    output logic         gnt_preta,
    output logic         registraJ,
    output logic         vez,
    output logic [W-1:0] tempo_branca,
    output logic [W-1:0] tempo_preta,
    output logic         fim_branca,
    output logic         fim_preta,
    output logic         em_jogo,
    output logic [3:0]   db_estado
);

    typedef enum logic [3:0] {
        OCIOSO   = 4'h0,
        PREPARA  = 4'h1,
        VEZ      = 4'h2,
        REGISTRA = 4'h3,
        VALIDA   = 4'h4,
        TROCA    = 4'h5,
        PAUSA    = 4'h6,
        FIM      = 4'hF
    } estado_t;

    localparam logic [W-1:0] TEMPO_MAX   = '1;
    localparam logic [W-1:0] TEMPO_CARGA = W'(TEMPO_INICIAL);
    // Clamp the increment so its extended form never wraps before saturation.
    localparam int           INC_SAT     = (INCREMENTO > (2**W - 1)) ? (2**W - 1) : INCREMENTO;
    localparam logic [W:0]   INC_EXT     = (W+1)'(INC_SAT);

    estado_t      estado_q, estado_d;
    logic         vez_q, vez_d;
    logic [W-1:0] tempo_b_q, tempo_b_d;
    logic [W-1:0] tempo_p_q, tempo_p_d;
    logic         fim_b_q, fim_b_d;
    logic         fim_p_q, fim_p_d;

    logic         conta;
    logic         expira;
    logic         req_vez;
    logic [W-1:0] tempo_vez;

    function automatic logic [W-1:0] soma_sat(input logic [W-1:0] t);
        logic [W:0] s;
        s = {1'b0, t} + INC_EXT;
        return s[W] ? TEMPO_MAX : s[W-1:0];
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            vez_q     <= 1'b0;
            tempo_b_q <= '0;
            tempo_p_q <= '0;
            fim_b_q   <= 1'b0;
            fim_p_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            vez_q     <= vez_d;
            tempo_b_q <= tempo_b_d;
            tempo_p_q <= tempo_p_d;
            fim_b_q   <= fim_b_d;
            fim_p_q   <= fim_p_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        vez_d     = vez_q;
        tempo_b_d = tempo_b_q;
        tempo_p_d = tempo_p_q;
        fim_b_d   = fim_b_q;
        fim_p_d   = fim_p_q;

        tempo_vez = vez_q ? tempo_p_q : tempo_b_q;
        req_vez   = vez_q ? req_preta : req_branca;
        conta     = tick && (estado_q == VEZ || estado_q == REGISTRA || estado_q == VALIDA)
                    && (tempo_vez != '0);
        expira    = conta && (tempo_vez == W'(1));

        if (conta) begin
            if (vez_q) tempo_p_d = tempo_p_q - W'(1);
            else       tempo_b_d = tempo_b_q - W'(1);
        end

        case (estado_q)
            OCIOSO: begin
                if (iniciar) estado_d = PREPARA;
            end
            PREPARA: begin
                tempo_b_d = TEMPO_CARGA;
                tempo_p_d = TEMPO_CARGA;
                vez_d     = 1'b0;
                fim_b_d   = 1'b0;
                fim_p_d   = 1'b0;
                estado_d  = VEZ;
            end
            VEZ: begin
                if (pausar)       estado_d = PAUSA;
                else if (req_vez) estado_d = REGISTRA;
            end
            REGISTRA: begin
                estado_d = VALIDA;
            end
            VALIDA: begin
                if (jogada_valida)        estado_d = TROCA;
                else if (jogada_invalida) estado_d = VEZ;
            end
            TROCA: begin
                if (vez_q) tempo_p_d = soma_sat(tempo_p_q);
                else       tempo_b_d = soma_sat(tempo_b_q);
                vez_d    = ~vez_q;
                estado_d = VEZ;
            end
            PAUSA: begin
                if (!pausar) estado_d = VEZ;
            end
            FIM: begin
                if (iniciar) estado_d = PREPARA;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        // Expiry overrides any request, verdict or pause seen on the same edge.
        if (expira) begin
            estado_d = FIM;
            if (vez_q) fim_p_d = 1'b1;
            else       fim_b_d = 1'b1;
        end
    end

    assign gnt_branca   = (estado_q == REGISTRA || estado_q == VALIDA) && !vez_q;
    assign gnt_preta    = (estado_q == REGISTRA || estado_q == VALIDA) &&  vez_q;
    assign registraJ    = (estado_q == REGISTRA);
    assign vez          = vez_q;
    assign tempo_branca = tempo_b_q;
    assign tempo_preta  = tempo_p_q;
    assign fim_branca   = fim_b_q;
    assign fim_preta    = fim_p_q;
    assign em_jogo      = (estado_q == VEZ) || (estado_q == REGISTRA) || (estado_q == VALIDA)
                          || (estado_q == TROCA) || (estado_q == PAUSA);
    assign db_estado    = estado_q;

endmodule
